// File: rtl/serial_rx_pkg.sv
// Shared types and default constants for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam int              DATA_W_DEF       = 8;
  localparam int              SYNC_W_DEF       = 4;
  localparam logic [3:0]      SYNC_PATTERN_DEF = 4'b1011;

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in / parallel-out shift register with enable and synchronous clear.
// LSB_FIRST=0: bits enter at the LSB, so the first bit ends up at the MSB.
// LSB_FIRST=1: bits enter at the MSB, so after WIDTH shifts the first bit
//              sits at bit 0 (payload[counter] ordering).
module rx_shift_reg
  import serial_rx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: clear wins over shift; hold when not enabled.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      if (LSB_FIRST) begin
        data_d = {bit_i, data_q[WIDTH-1:1]};
      end else begin
        data_d = {data_q[WIDTH-2:0], bit_i};
      end
    end
  end

  // Register update.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, collects an LSB-first
// payload, checks even parity and presents the byte on a valid/ready
// output register with a sticky overrun flag.
//
// state  | meaning
// HUNT   | shifting bits into the sync register, waiting for SYNC_PATTERN
// DATA   | collecting payload bits, counter indexes the next payload bit
// PARITY | next sampled bit is the parity bit that completes the frame
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int                DATA_W       = DATA_W_DEF,
  parameter int                SYNC_W       = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_PATTERN_DEF)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              data_in_i,
  input  logic              bit_en_i,
  input  logic              byte_ready_i,
  output logic [DATA_W-1:0] byte_out_o,
  output logic              byte_valid_o,
  output logic              parity_err_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  byte_q, byte_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               ovr_q, ovr_d;

  logic [SYNC_W-1:0]  sync_q;
  logic [DATA_W-1:0]  payload_q;
  logic [SYNC_W-1:0]  sync_shift;
  logic               sync_hit;
  logic               sync_clr;
  logic               sync_en;
  logic               pay_en;
  logic               frame_done;
  logic               par_mis;
  logic               accept;

  // The sync register is held clear outside HUNT so that any return to HUNT
  // starts from zero and frame bits can never contribute to a sync match.
  assign sync_clr = !reset_i || (state_q != HUNT);
  assign sync_en  = bit_en_i && (state_q == HUNT);
  assign pay_en   = bit_en_i && (state_q == DATA);

  rx_shift_reg #(
    .WIDTH     (SYNC_W),
    .LSB_FIRST (1'b0)
  ) u_sync_sr (
    .clk_i  (clk_i),
    .clr_i  (sync_clr),
    .en_i   (sync_en),
    .bit_i  (data_in_i),
    .data_o (sync_q)
  );

  // Payload is fully overwritten every frame, so only reset clears it.
  rx_shift_reg #(
    .WIDTH     (DATA_W),
    .LSB_FIRST (1'b1)
  ) u_payload_sr (
    .clk_i  (clk_i),
    .clr_i  (!reset_i),
    .en_i   (pay_en),
    .bit_i  (data_in_i),
    .data_o (payload_q)
  );

  // Match is judged on the post-shift sync value, allowing overlapping hits.
  assign sync_shift = {sync_q[SYNC_W-2:0], data_in_i};
  assign sync_hit   = (sync_shift == SYNC_PATTERN);

  assign frame_done = bit_en_i && (state_q == PARITY);
  assign par_mis    = (^payload_q) ^ data_in_i;
  assign accept     = frame_done && (!valid_q || byte_ready_i);

  // Next-state, counter and output-register decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovr_d   = ovr_q;

    case (state_q)
      HUNT: begin
        if (bit_en_i && sync_hit) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (bit_en_i) begin
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_en_i) begin
          state_d = HUNT;
        end
      end
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
      end
    endcase

    // A completed frame loads if the slot is free or being freed this edge;
    // otherwise it is dropped and the old byte is kept.
    if (accept) begin
      byte_d  = payload_q;
      err_d   = par_mis;
      valid_d = 1'b1;
    end else if (frame_done) begin
      ovr_d = 1'b1;
    end else if (valid_q && byte_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign byte_out_o   = byte_q;
  assign byte_valid_o = valid_q;
  assign parity_err_o = err_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != HUNT);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: a directed vector table, hand
// sequences for multi-cycle corner cases, and randomized traffic compared
// against a frame-level reference model.
module tb_serial_frame_rx;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic       bit_en;
  logic       byte_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_frame_rx dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .data_in_i    (data_in),
    .bit_en_i     (bit_en),
    .byte_ready_i (byte_ready),
    .byte_out_o   (byte_out),
    .byte_valid_o (byte_valid),
    .parity_err_o (parity_err),
    .overrun_o    (overrun),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       din;
    logic       rdy;
    logic       ev;
    logic [7:0] eo;
    logic       ee;
    logic       eovr;
    logic       ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input logic d, input logic y,
                              input logic v, input logic [7:0] o, input logic er,
                              input logic ov, input logic b);
    vec_t t;
    t = '{r, e, d, y, v, o, er, ov, b};
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    bit_en  = 1'b1;
    tick();
  endtask

  task automatic gap();
    bit_en  = 1'b0;
    data_in = 1'($urandom);
    tick();
  endtask

  // Sync word, LSB-first payload, then parity with byte_ready forced to rdy_last.
  task automatic send_frame(input logic [7:0] v, input logic p, input bit gaps, input logic rdy_last);
    logic [3:0] sp;
    sp = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      send_bit(sp[i]);
      if (gaps) gap();
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      if (gaps) gap();
    end
    byte_ready = rdy_last;
    send_bit(p);
    bit_en = 1'b0;
  endtask

  // ---------------- reference model (frame-level) ----------------
  bit         m_hunt;
  bit         m_hist[$];
  bit         m_pay[$];
  logic [7:0] m_out;
  bit         m_err, m_valid, m_ovr;

  task automatic model_edge(input bit rst_n, input bit en, input bit din, input bit rdy);
    bit         done;
    logic [7:0] fv;
    int         ones;
    int         w;
    int         idx;
    done = 0;
    fv   = '0;
    ones = 0;
    if (!rst_n) begin
      m_hunt  = 1;
      m_hist.delete();
      m_pay.delete();
      m_out   = '0;
      m_err   = 0;
      m_valid = 0;
      m_ovr   = 0;
      return;
    end
    if (en) begin
      if (m_hunt) begin
        m_hist.push_back(din);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        w = 0;
        for (int i = 0; i < 4; i++) begin
          idx = m_hist.size() - 4 + i;
          w = (w << 1) | ((idx >= 0) ? int'(m_hist[idx]) : 0);
        end
        if (w == 'b1011) begin
          m_hunt = 0;
          m_hist.delete();
          m_pay.delete();
        end
      end else if (m_pay.size() < 8) begin
        m_pay.push_back(din);
      end else begin
        done = 1;
        ones = int'(din);
        for (int i = 0; i < 8; i++) begin
          fv[i] = m_pay[i];
          ones += int'(m_pay[i]);
        end
        m_hunt = 1;
      end
    end
    if (done && (!m_valid || rdy)) begin
      m_out   = fv;
      m_err   = (ones % 2) != 0;
      m_valid = 1;
    end else if (done) begin
      m_ovr = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  initial begin
    reset      = 1'b0;
    data_in    = 1'b0;
    bit_en     = 1'b0;
    byte_ready = 1'b0;

    // Reset held for 3 edges with random inputs.
    for (int i = 0; i < 3; i++) begin
      data_in = 1'($urandom);
      bit_en  = 1'($urandom);
      tick();
    end
    chk("rst_out",   byte_out,   8'h00);
    chk("rst_valid", byte_valid, 1'b0);
    chk("rst_err",   parity_err, 1'b0);
    chk("rst_ovr",   overrun,    1'b0);
    chk("rst_busy",  busy,       1'b0);

    // Good frame 0xA5, parity 0, byte_ready=1 throughout.
    add(0,1,1,1, 0,8'h00,0,0,0);
    add(1,1,1,1, 0,8'h00,0,0,0);
    add(1,1,0,1, 0,8'h00,0,0,0);
    add(1,1,1,1, 0,8'h00,0,0,0);
    add(1,1,1,1, 0,8'h00,0,0,1);
    add(1,1,1,1, 0,8'h00,0,0,1);
    add(1,1,0,1, 0,8'h00,0,0,1);
    add(1,1,1,1, 0,8'h00,0,0,1);
    add(1,1,0,1, 0,8'h00,0,0,1);
    add(1,1,0,1, 0,8'h00,0,0,1);
    add(1,1,1,1, 0,8'h00,0,0,1);
    add(1,1,0,1, 0,8'h00,0,0,1);
    add(1,1,1,1, 0,8'h00,0,0,1);
    add(1,1,0,1, 1,8'hA5,0,0,0);
    add(1,0,0,1, 0,8'hA5,0,0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      reset      = tbl[i].rst_n;
      bit_en     = tbl[i].en;
      data_in    = tbl[i].din;
      byte_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), byte_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_out", i),   byte_out,   tbl[i].eo);
      chk($sformatf("tbl%0d_err", i),   parity_err, tbl[i].ee);
      chk($sformatf("tbl%0d_ovr", i),   overrun,    tbl[i].eovr);
      chk($sformatf("tbl%0d_busy", i),  busy,       tbl[i].ebusy);
    end

    // Parity error with strobe gaps.
    byte_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1, 1'b1);
    chk("gap_valid", byte_valid, 1'b1);
    chk("gap_out",   byte_out,   8'hA5);
    chk("gap_err",   parity_err, 1'b1);
    chk("gap_busy",  busy,       1'b0);
    tick();
    chk("gap_valid_drop", byte_valid, 1'b0);

    // Overrun, then replacement on the completion edge.
    byte_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    chk("ovr1_valid", byte_valid, 1'b1);
    chk("ovr1_out",   byte_out,   8'h3C);
    chk("ovr1_ovr",   overrun,    1'b0);
    send_frame(8'h0F, 1'b0, 0, 1'b0);
    chk("ovr2_valid", byte_valid, 1'b1);
    chk("ovr2_out",   byte_out,   8'h3C);
    chk("ovr2_ovr",   overrun,    1'b1);
    send_frame(8'h81, 1'b0, 0, 1'b1);
    chk("b2b_valid", byte_valid, 1'b1);
    chk("b2b_out",   byte_out,   8'h81);
    chk("b2b_err",   parity_err, 1'b0);
    chk("b2b_ovr",   overrun,    1'b1);
    tick();
    chk("b2b_drop", byte_valid, 1'b0);

    // Overlapping sync, payload containing 1011.
    byte_ready = 1'b1;
    reset = 1'b0; bit_en = 1'b0; tick(); reset = 1'b1;
    chk("ovl_ovr_clr", overrun, 1'b0);
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    chk("ovl_busy5", busy, 1'b0);
    send_bit(1);
    chk("ovl_busy6", busy, 1'b1);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("ovl_busy_mid", busy, 1'b1);
    send_bit(0); send_bit(0); send_bit(0); send_bit(0);
    send_bit(1);
    chk("ovl_valid", byte_valid, 1'b1);
    chk("ovl_out",   byte_out,   8'h0D);
    chk("ovl_err",   parity_err, 1'b0);
    chk("ovl_busy_end", busy,    1'b0);

    // Mid-frame reset.
    byte_ready = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    reset = 1'b0; bit_en = 1'b1; data_in = 1'b1; tick();
    chk("mfr_busy_rst",  busy,       1'b0);
    chk("mfr_valid_rst", byte_valid, 1'b0);
    reset = 1'b1; bit_en = 1'b0; tick();
    chk("mfr_busy_after", busy, 1'b0);
    send_frame(8'h5A, 1'b0, 0, 1'b1);
    chk("mfr_valid", byte_valid, 1'b1);
    chk("mfr_out",   byte_out,   8'h5A);
    chk("mfr_err",   parity_err, 1'b0);

    // Randomized traffic against the reference model.
    reset = 1'b0; bit_en = 1'b0; byte_ready = 1'b0;
    model_edge(0, 0, 0, 0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) != 0);
      bit_en     = ($urandom_range(0, 3) != 0);
      data_in    = 1'($urandom);
      byte_ready = ($urandom_range(0, 2) == 0);
      model_edge(reset, bit_en, data_in, byte_ready);
      tick();
      chk("rnd_valid", byte_valid, m_valid);
      chk("rnd_out",   byte_out,   m_out);
      chk("rnd_err",   parity_err, m_err);
      chk("rnd_ovr",   overrun,    m_ovr);
      chk("rnd_busy",  busy,       !m_hunt);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
